// File: rtl/npc_mem_pkg.sv
// Shared definitions for the physical-memory responder.
// Contents: responder FSM state enum, data/mask widths, default base address.
package npc_mem_pkg;

   localparam int WORD_W = 64;
   localparam int MASK_W = WORD_W / 8;
   localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      COMMIT = 2'd2,
      RESP   = 2'd3
   } pmemState_t;

endpackage

// File: rtl/pmem_word_array.sv
// 64-bit word array: synchronous byte-masked write, registered read.
// Ports:
//   clk    - clock
//   we     - write enable; bytes selected by wmask are updated at idx
//   wmask  - byte enables, bit i covers wdata[8i+7:8i]
//   wdata  - write data
//   re     - read enable; rdata captures the word at idx
//   idx    - word index shared by read and write
//   rdata  - registered read data (holds until the next read)
module pmem_word_array
   import npc_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [MASK_W-1:0] wmask,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  idx,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) rdata <= mem[idx];
   end

endmodule

// File: rtl/pmem_responder.sv
// Memory-side responder for the core's data-memory request interface.
// One request is in flight at a time: it is latched on the request
// handshake, committed to the word array LATENCY cycles later, and the
// response is held until the requester accepts it.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   req_valid/req_ready          - request handshake
//   req_wen, req_addr            - 1 = write; byte address (bits [2:0] ignored)
//   req_wdata, req_wmask         - write data and byte enables
//   resp_valid/resp_ready        - response handshake
//   resp_rdata                   - read data (0 for writes and errors)
//   resp_err                     - address outside the backed window
module pmem_responder
   import npc_mem_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [63:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [MASK_W-1:0] req_wmask,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int          IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) << 3;

   pmemState_t        state, stateNext;
   logic [3:0]        cnt, cntNext;
   logic              latWen;
   logic [63:0]       latAddr;
   logic [WORD_W-1:0] latWdata;
   logic [MASK_W-1:0] latWmask;
   logic              rdHit;
   logic              errQ;

   // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
   logic [63:0]       offset;
   logic              inRange;
   logic              arrWe, arrRe;
   logic [WORD_W-1:0] arrRdata;

   assign offset  = latAddr - BASE_ADDR;
   assign inRange = offset < SPAN;
   assign arrWe   = (state == COMMIT) && latWen && inRange;
   assign arrRe   = (state == COMMIT) && !latWen && inRange;

   pmem_word_array #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W)) uArray (
      .clk   (clk),
      .we    (arrWe),
      .wmask (latWmask),
      .wdata (latWdata),
      .re    (arrRe),
      .idx   (offset[IDX_W+2:3]),
      .rdata (arrRdata)
   );

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      case (state)
         IDLE: begin
            if (req_valid) begin
               cntNext   = 4'(LATENCY - 1);
               stateNext = (LATENCY > 1) ? WAIT : COMMIT;
            end
         end
         WAIT: begin
            cntNext = cnt - 4'd1;
            if (cnt == 4'd1) stateNext = COMMIT;
         end
         COMMIT:  stateNext = RESP;
         RESP:    if (resp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rdHit <= 1'b0;
         errQ  <= 1'b0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         if (state == IDLE && req_valid) begin
            latWen   <= req_wen;
            latAddr  <= req_addr;
            latWdata <= req_wdata;
            latWmask <= req_wmask;
         end
         if (state == COMMIT) begin
            errQ  <= !inRange;
            rdHit <= inRange && !latWen;
         end else if (state == RESP && resp_ready) begin
            errQ  <= 1'b0;
            rdHit <= 1'b0;
         end
      end
   end

   // The array read register is not reset; rdHit masks it so resp_rdata
   // is zero out of reset and for writes/errors.
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_err   = errQ;
   assign resp_rdata = rdHit ? arrRdata : '0;

endmodule

// File: tb/tb_pmem_responder.sv
module tb_pmem_responder;
   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
   localparam int          DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst [2];
   logic        rv [2], rw [2], rr [2];
   logic [63:0] ra [2], rwd [2];
   logic [7:0]  rm [2];
   logic        rqr [2], rsv [2], rse [2];
   logic [63:0] rsd [2];

   int          lat [2] = '{2, 1};
   logic [63:0] mdl [2][DEPTH];
   int          vecs = 0;
   int          miss = 0;

   always #5 clk = ~clk;

   pmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
      .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_ready(rqr[0]),
      .req_wen(rw[0]), .req_addr(ra[0]), .req_wdata(rwd[0]), .req_wmask(rm[0]),
      .resp_valid(rsv[0]), .resp_ready(rr[0]), .resp_rdata(rsd[0]), .resp_err(rse[0])
   );

   pmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_ready(rqr[1]),
      .req_wen(rw[1]), .req_addr(ra[1]), .req_wdata(rwd[1]), .req_wmask(rm[1]),
      .resp_valid(rsv[1]), .resp_ready(rr[1]), .resp_rdata(rsd[1]), .resp_err(rse[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: the window is [BASE, BASE+8*DEPTH); model memory is byte-merged.
   task automatic doReq(input int d, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [7:0] wm, input int hold,
                        output logic [63:0] got, output logic gotErr);
      logic [63:0] expD;
      logic        expE;
      int          idx;
      expD = '0;
      expE = 1'b1;
      if (addr >= BASE && addr < BASE + 64'(DEPTH) * 8) begin
         expE = 1'b0;
         idx  = int'((addr - BASE) / 8);
         if (wen) begin
            for (int b = 0; b < 8; b++)
               if (wm[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
         end else expD = mdl[d][idx];
      end
      @(negedge clk);
      chk("req_ready_idle", 64'(rqr[d]), 64'd1);
      rv[d] = 1'b1; rw[d] = wen; ra[d] = addr; rwd[d] = wd; rm[d] = wm;
      @(posedge clk); #1;
      rv[d] = 1'b0; rw[d] = 1'($urandom); ra[d] = {$urandom, $urandom};
      rwd[d] = {$urandom, $urandom}; rm[d] = 8'($urandom);
      for (int k = 0; k < lat[d]; k++) begin
         chk("valid_early", 64'(rsv[d]), 64'd0);
         @(posedge clk); #1;
      end
      chk("valid_on_time", 64'(rsv[d]), 64'd1);
      chk("rdata", rsd[d], expD);
      chk("err", 64'(rse[d]), 64'(expE));
      got = rsd[d];
      gotErr = rse[d];
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", 64'(rsv[d]), 64'd1);
         chk("hold_rdata", rsd[d], expD);
         chk("hold_err", 64'(rse[d]), 64'(expE));
         chk("hold_req_ready", 64'(rqr[d]), 64'd0);
      end
      rr[d] = 1'b1;
      @(posedge clk); #1;
      rr[d] = 1'b0;
      chk("valid_drop", 64'(rsv[d]), 64'd0);
      chk("ready_back", 64'(rqr[d]), 64'd1);
   endtask

   initial begin
      logic [63:0] got;
      logic        gotErr;
      logic [63:0] a;
      int          r;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; rv[d] = 1'b0; rw[d] = 1'b0; rr[d] = 1'b0;
         ra[d] = '0; rwd[d] = '0; rm[d] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", 64'(rqr[d]), 64'd1);
         chk("rst_resp_valid", 64'(rsv[d]), 64'd0);
         chk("rst_rdata", rsd[d], 64'd0);
         chk("rst_err", 64'(rse[d]), 64'd0);
      end

      // Fill the words the random phase may read so no read returns X.
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < 16; w++)
            doReq(d, 1'b1, BASE + 64'(w) * 8, {$urandom, $urandom}, 8'hFF, 0, got, gotErr);
         doReq(d, 1'b1, BASE + 64'h1FF8, {$urandom, $urandom}, 8'hFF, 0, got, gotErr);
      end

      // Full write then read back.
      doReq(0, 1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 0, got, gotErr);
      chk("write_rdata_zero", got, 64'd0);
      doReq(0, 1'b0, 64'h8000_0010, '0, '0, 0, got, gotErr);
      chk("full_readback", got, 64'h1122334455667788);
      // Partial write, low nibble of mask.
      doReq(0, 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, got, gotErr);
      doReq(0, 1'b0, 64'h8000_0010, '0, '0, 0, got, gotErr);
      chk("partial_readback", got, 64'h11223344AAAAAAAA);
      doReq(0, 1'b0, 64'h8000_0014, '0, '0, 0, got, gotErr);
      chk("lowbits_ignored", got, 64'h11223344AAAAAAAA);
      // wmask=0 write is a no-op with a normal response.
      doReq(0, 1'b1, 64'h8000_0010, 64'h0, 8'h00, 0, got, gotErr);
      chk("mask0_err", 64'(gotErr), 64'd0);
      doReq(0, 1'b0, 64'h8000_0010, '0, '0, 0, got, gotErr);
      chk("mask0_unchanged", got, 64'h11223344AAAAAAAA);
      // Range boundaries.
      doReq(0, 1'b0, 64'h7FFF_FFF8, '0, '0, 0, got, gotErr);
      chk("below_base_err", 64'(gotErr), 64'd1);
      doReq(0, 1'b0, 64'h8000_2000, '0, '0, 0, got, gotErr);
      chk("past_top_err", 64'(gotErr), 64'd1);
      doReq(0, 1'b0, 64'h8000_1FF8, '0, '0, 0, got, gotErr);
      chk("top_word_ok", 64'(gotErr), 64'd0);
      // Response held with resp_ready low for 5 cycles.
      doReq(0, 1'b0, 64'h8000_0010, '0, '0, 5, got, gotErr);

      // Reset during WAIT drops the pending write.
      @(negedge clk);
      rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = BASE + 64'h20;
      rwd[0] = ~mdl[0][4]; rm[0] = 8'hFF;
      @(posedge clk); #1;
      rv[0] = 1'b0; rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      chk("rst_mid_ready", 64'(rqr[0]), 64'd1);
      chk("rst_mid_valid", 64'(rsv[0]), 64'd0);
      doReq(0, 1'b0, BASE + 64'h20, '0, '0, 0, got, gotErr);
      chk("rst_mid_old_word", got, mdl[0][4]);

      // LATENCY=1 instance: directed read-after-write.
      doReq(1, 1'b1, BASE + 64'h20, 64'hDEAD_BEEF_0123_4567, 8'hF0, 1, got, gotErr);
      doReq(1, 1'b0, BASE + 64'h20, '0, '0, 0, got, gotErr);

      // Random traffic on both instances.
      for (int i = 0; i < 120; i++) begin
         r = int'($urandom_range(0, 19));
         if (r < 16)       a = BASE + 64'(r) * 8 + 64'($urandom_range(0, 7));
         else if (r == 16) a = BASE + 64'h1FF8;
         else if (r == 17) a = BASE + 64'(DEPTH) * 8;
         else if (r == 18) a = BASE - 64'd8;
         else              a = {1'b1, 31'($urandom), $urandom};
         doReq(i % 2, 1'($urandom), a, {$urandom, $urandom}, 8'($urandom),
               int'($urandom_range(0, 2)), got, gotErr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
